// File: rtl/bt_rx_frame_ctrl.sv
// rtl/bt_rx_frame_ctrl.sv - byte stream to command frame controller (optional checksum: BT_RX_CHECKSUM_EN)
module bt_rx_frame_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_LEN        = 8,
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        rx_avail,
    input  logic [7:0]  rx_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_len,
    output logic [63:0] cmd_data,
    output logic        frame_err,
    output logic        overrun,
    output logic [7:0]  err_count,
    output logic        busy
);

    // Idle counter only needs to hold TIMEOUT_CYCLES-1; the terminal value fires the abort.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef BT_RX_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, LEN, PAYLOAD} state_t;
`endif

    state_t             state;
    logic [3:0]         len_q;
    logic [3:0]         bytecnt;
    logic [63:0]        payload_buf;
    logic [CNT_W-1:0]   idle_cnt;
`ifdef BT_RX_CHECKSUM_EN
    logic [7:0]         chk_q;
`endif

    logic               timeout_hit;
    logic               byte_ok;
    logic               len_ok;
    logic               last_byte;
    logic               complete;
    logic               bad_byte;
    logic               load_cmd;
    logic               drop_good;
    logic               err_now;
    logic [63:0]        buf_next;
    logic [63:0]        cmd_src;

    // Per-cycle frame decisions; a timeout wins over a byte arriving in the same cycle.
    always_comb begin
        timeout_hit = (state != IDLE) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        byte_ok     = rx_avail && !timeout_hit;
        len_ok      = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
        last_byte   = (bytecnt == (len_q - 4'd1));
        buf_next    = payload_buf;
        buf_next[{bytecnt[2:0], 3'b000} +: 8] = rx_data;
`ifdef BT_RX_CHECKSUM_EN
        complete    = byte_ok && (state == CHECK) && (rx_data == chk_q);
        bad_byte    = byte_ok && (((state == LEN) && !len_ok) ||
                                  ((state == CHECK) && (rx_data != chk_q)));
        cmd_src     = payload_buf;
`else
        complete    = byte_ok && (state == PAYLOAD) && last_byte;
        bad_byte    = byte_ok && (state == LEN) && !len_ok;
        cmd_src     = buf_next;
`endif
        // A consumer accepting in the completion cycle frees the slot for the new frame.
        load_cmd    = complete && (!cmd_valid || cmd_ready);
        drop_good   = complete && cmd_valid && !cmd_ready;
        err_now     = timeout_hit || bad_byte || drop_good;
    end

    // Frame FSM, idle timer, command holding register and error reporting.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= IDLE;
            len_q       <= 4'd0;
            bytecnt     <= 4'd0;
            payload_buf <= 64'd0;
            idle_cnt    <= '0;
`ifdef BT_RX_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
            cmd_valid   <= 1'b0;
            cmd_len     <= 4'd0;
            cmd_data    <= 64'd0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            frame_err <= err_now;
            overrun   <= drop_good;
            if (err_now && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (load_cmd) begin
                cmd_valid <= 1'b1;
                cmd_len   <= len_q;
                cmd_data  <= cmd_src;
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            if (timeout_hit || (state == IDLE) || rx_avail) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end

            if (timeout_hit) begin
                state <= IDLE;
            end else if (rx_avail) begin
                case (state)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state <= LEN;
                        end
                    end
                    LEN: begin
                        if (len_ok) begin
                            len_q       <= rx_data[3:0];
                            bytecnt     <= 4'd0;
                            payload_buf <= 64'd0;
`ifdef BT_RX_CHECKSUM_EN
                            chk_q       <= rx_data;
`endif
                            state       <= PAYLOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        payload_buf <= buf_next;
                        bytecnt     <= bytecnt + 4'd1;
`ifdef BT_RX_CHECKSUM_EN
                        chk_q       <= chk_q ^ rx_data;
                        if (last_byte) begin
                            state <= CHECK;
                        end
`else
                        if (last_byte) begin
                            state <= IDLE;
                        end
`endif
                    end
`ifdef BT_RX_CHECKSUM_EN
                    CHECK: begin
                        state <= IDLE;
                    end
`endif
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bt_rx_frame_ctrl.sv
// tb/tb_bt_rx_frame_ctrl.sv - scoreboard bench for bt_rx_frame_ctrl
module tb_bt_rx_frame_ctrl;

    localparam int TO = 16;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        rx_avail;
    logic [7:0]  rx_data;
    logic        cmd_ready;
    logic        cmd_valid;
    logic [3:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        frame_err;
    logic        overrun;
    logic [7:0]  err_count;
    logic        busy;

    bt_rx_frame_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .MAX_LEN(8),
        .SYNC_BYTE(8'hAA)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .rx_avail(rx_avail),
        .rx_data(rx_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len(cmd_len),
        .cmd_data(cmd_data),
        .frame_err(frame_err),
        .overrun(overrun),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [3:0]  len;
        logic [63:0] data;
    } cmd_t;

    cmd_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int exp_err = 0;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk_in) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_avail = 1'b1;
        rx_data  = b;
        cyc(1);
        rx_avail = 1'b0;
    endtask

    task automatic bump_err();
        if (exp_err < 255) exp_err++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rx_avail  = 1'b0;
        cmd_ready = 1'b0;
        cyc(2);
        reset     = 1'b0;
        exp_err   = 0;
        exp_q.delete();
    endtask

    task automatic send_frame(input int len, input logic [63:0] data, input bit ready_last);
        logic [7:0] chk;
        chk = 8'(len);
        send_byte(8'hAA);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            chk ^= data[8*i +: 8];
`ifndef BT_RX_CHECKSUM_EN
            if ((i == len - 1) && ready_last) cmd_ready = 1'b1;
`endif
            send_byte(data[8*i +: 8]);
        end
`ifdef BT_RX_CHECKSUM_EN
        if (ready_last) cmd_ready = 1'b1;
        send_byte(chk);
`endif
        cmd_ready = 1'b0;
    endtask

    task automatic push_exp(input int len, input logic [63:0] data);
        cmd_t e;
        e.len  = 4'(len);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic accept_cmd(input string name);
        cmd_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: scoreboard empty, cmd_valid=%0b", name, cmd_valid);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (cmd_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid: got %0b want 1", name, cmd_valid);
            end
            checks++;
            if (cmd_len !== e.len) begin
                errors++;
                $display("FAIL %s_len: got %0d want %0d", name, cmd_len, e.len);
            end
            checks++;
            if (cmd_data !== e.data) begin
                errors++;
                $display("FAIL %s_data: got %h want %h", name, cmd_data, e.data);
            end
        end
        cmd_ready = 1'b1;
        cyc(1);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_clear: cmd_valid got %0b want 0", name, cmd_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid: got %0b want 0", cmd_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %0b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %0b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (cmd_len !== 4'd0) begin errors++; $display("FAIL rst_cmd_len: got %0d want 0", cmd_len); end
        checks++; if (cmd_data !== 64'd0) begin errors++; $display("FAIL rst_cmd_data: got %h want 0", cmd_data); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_good_frame();
        int fe0;
        fe0 = fe_seen;
        push_exp(3, 64'h0000_0000_0033_2211);
        send_frame(3, 64'h0000_0000_0033_2211, 1'b0);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL good_valid_latency: got %0b want 1", cmd_valid); end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL good_err_count: got %0d want %0d", err_count, exp_err); end
        accept_cmd("good");
        checks++; if (fe_seen !== fe0) begin errors++; $display("FAIL good_no_err: got %0d pulses want 0", fe_seen - fe0); end
    endtask

`ifdef BT_RX_CHECKSUM_EN
    task automatic test_bad_checksum();
        int fe0;
        fe0 = fe_seen;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h55); send_byte(8'h66); send_byte(8'h00);
        bump_err();
        cyc(1);
        checks++; if (fe_seen !== fe0 + 1) begin errors++; $display("FAIL badchk_pulses: got %0d want 1", fe_seen - fe0); end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL badchk_err_count: got %0d want %0d", err_count, exp_err); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL badchk_valid: got %0b want 0", cmd_valid); end
        push_exp(1, 64'h5A);
        send_frame(1, 64'h5A, 1'b0);
        accept_cmd("badchk_next");
    endtask
`endif

    task automatic test_len_errors();
        int fe0;
        fe0 = fe_seen;
        send_byte(8'h12); send_byte(8'h34);
        cyc(1);
        checks++; if (fe_seen !== fe0) begin errors++; $display("FAIL garbage_err: got %0d pulses want 0", fe_seen - fe0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garbage_busy: got %0b want 0", busy); end
        send_byte(8'hAA); send_byte(8'h00);
        bump_err();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL len0_pulse: got %0b want 1", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_idle: busy got %0b want 0", busy); end
        send_byte(8'hAA); send_byte(8'h09);
        bump_err();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL len9_pulse: got %0b want 1", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len9_idle: busy got %0b want 0", busy); end
        cyc(1);
        checks++; if (fe_seen !== fe0 + 2) begin errors++; $display("FAIL len_pulses: got %0d want 2", fe_seen - fe0); end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL len_err_count: got %0d want %0d", err_count, exp_err); end
        push_exp(8, 64'h8877_6655_4433_2211);
        send_frame(8, 64'h8877_6655_4433_2211, 1'b0);
        accept_cmd("len8");
    endtask

    task automatic test_overrun();
        int fe0, ov0;
        fe0 = fe_seen;
        ov0 = ov_seen;
        push_exp(2, 64'h0201);
        send_frame(2, 64'h0201, 1'b0);
        cyc(2);
        send_frame(1, 64'h77, 1'b0);
        bump_err();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %0b want 1", overrun); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ovr_frame_err: got %0b want 1", frame_err); end
        cyc(1);
        checks++; if ((ov_seen - ov0) !== 1) begin errors++; $display("FAIL ovr_count: got %0d want 1", ov_seen - ov0); end
        checks++; if ((fe_seen - fe0) !== 1) begin errors++; $display("FAIL ovr_fe_count: got %0d want 1", fe_seen - fe0); end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL ovr_err_count: got %0d want %0d", err_count, exp_err); end
        accept_cmd("ovr_keepA");
    endtask

    task automatic test_back_to_back();
        int ov0;
        cmd_t e;
        ov0 = ov_seen;
        push_exp(2, 64'hAAAA);
        send_frame(2, 64'hAAAA, 1'b0);
        e = exp_q.pop_front();
        checks++; if (cmd_data !== e.data || cmd_len !== e.len) begin errors++; $display("FAIL b2b_first: got %0d/%h want %0d/%h", cmd_len, cmd_data, e.len, e.data); end
        push_exp(3, 64'h00AA_5544);
        send_frame(3, 64'h00AA_5544, 1'b1);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held: got %0b want 1", cmd_valid); end
        checks++; if (ov_seen !== ov0) begin errors++; $display("FAIL b2b_no_overrun: got %0d pulses want 0", ov_seen - ov0); end
        accept_cmd("b2b_second");
    endtask

    task automatic test_timeout();
        int k;
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11);
        bump_err();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy: got %0b want 1", busy); end
        k = 0;
        while (frame_err !== 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        checks++; if (k !== TO) begin errors++; $display("FAIL to_latency: got %0d cycles want %0d", k, TO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: busy got %0b want 0", busy); end
        cyc(1);
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL to_err_count: got %0d want %0d", err_count, exp_err); end
    endtask

    task automatic test_reset_mid_frame();
        int fe0;
        push_exp(1, 64'h42);
        send_frame(1, 64'h42, 1'b0);
        fe0 = fe_seen;
        send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        exp_err = 0;
        exp_q.delete();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", busy); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", cmd_valid); end
        checks++; if (cmd_len !== 4'd0 || cmd_data !== 64'd0) begin errors++; $display("FAIL mid_cmd: got %0d/%h want 0/0", cmd_len, cmd_data); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_err_count: got %0d want 0", err_count); end
        cyc(TO + 4);
        checks++; if (fe_seen !== fe0) begin errors++; $display("FAIL mid_no_err: got %0d pulses want 0", fe_seen - fe0); end
    endtask

    task automatic test_saturation();
        int fe0;
        do_reset();
        fe0 = fe_seen;
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hAA);
            send_byte(8'h00);
            bump_err();
        end
        cyc(2);
        checks++; if ((fe_seen - fe0) !== 260) begin errors++; $display("FAIL sat_pulses: got %0d want 260", fe_seen - fe0); end
        checks++; if (err_count !== 8'(exp_err)) begin errors++; $display("FAIL sat_err_count: got %0d want %0d", err_count, exp_err); end
    endtask

    initial begin
        reset     = 1'b1;
        rx_avail  = 1'b0;
        rx_data   = 8'h00;
        cmd_ready = 1'b0;
        cyc(1);
        test_reset();
        test_good_frame();
`ifdef BT_RX_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_len_errors();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_reset_mid_frame();
        test_saturation();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
